// File: rtl/cpu_pkg.sv
// Shared ISA constants for the decode pipeline: opcodes, func codes, ALU
// operation codes, trap codes and the decoded-bundle record.
package cpu_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_SRL     = 6'h02;
   localparam logic [5:0] FN_SRA     = 6'h03;
   localparam logic [5:0] FN_SLLV    = 6'h04;
   localparam logic [5:0] FN_SRLV    = 6'h06;
   localparam logic [5:0] FN_SRAV    = 6'h07;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_XOR     = 6'h26;
   localparam logic [5:0] FN_NOR     = 6'h27;
   localparam logic [5:0] FN_SLT     = 6'h2A;
   localparam logic [5:0] FN_SLTU    = 6'h2B;

   localparam logic [4:0] RI_BLTZ    = 5'h00;
   localparam logic [4:0] RI_BGEZ    = 5'h01;
   localparam logic [4:0] RI_BAL     = 5'h11;

   localparam logic [5:0] ALU_STALL   = 6'd0;
   localparam logic [5:0] ALU_ADD     = 6'd1;
   localparam logic [5:0] ALU_ADDU    = 6'd2;
   localparam logic [5:0] ALU_SUB     = 6'd3;
   localparam logic [5:0] ALU_SUBU    = 6'd4;
   localparam logic [5:0] ALU_AND     = 6'd5;
   localparam logic [5:0] ALU_OR      = 6'd6;
   localparam logic [5:0] ALU_XOR     = 6'd7;
   localparam logic [5:0] ALU_NOR     = 6'd8;
   localparam logic [5:0] ALU_SLT     = 6'd9;
   localparam logic [5:0] ALU_SLTU    = 6'd10;
   localparam logic [5:0] ALU_SLL     = 6'd11;
   localparam logic [5:0] ALU_SRL     = 6'd12;
   localparam logic [5:0] ALU_SRA     = 6'd13;
   localparam logic [5:0] ALU_SLLV    = 6'd14;
   localparam logic [5:0] ALU_SRLV    = 6'd15;
   localparam logic [5:0] ALU_SRAV    = 6'd16;
   localparam logic [5:0] ALU_LUI     = 6'd17;
   localparam logic [5:0] ALU_BEQ     = 6'd18;
   localparam logic [5:0] ALU_BNE     = 6'd19;
   localparam logic [5:0] ALU_BGTZ    = 6'd20;
   localparam logic [5:0] ALU_BLEZ    = 6'd21;
   localparam logic [5:0] ALU_BLTZ    = 6'd22;
   localparam logic [5:0] ALU_BGEZ    = 6'd23;
   localparam logic [5:0] ALU_BAL     = 6'd24;
   localparam logic [5:0] ALU_J       = 6'd25;
   localparam logic [5:0] ALU_JAL     = 6'd26;
   localparam logic [5:0] ALU_JR      = 6'd27;
   localparam logic [5:0] ALU_JALR    = 6'd28;
   localparam logic [5:0] ALU_SYSCALL = 6'd29;
   localparam logic [5:0] ALU_MULT    = 6'd30;
   localparam logic [5:0] ALU_MULTU   = 6'd31;
   localparam logic [5:0] ALU_DIV     = 6'd32;
   localparam logic [5:0] ALU_DIVU    = 6'd33;
   localparam logic [5:0] ALU_MFHI    = 6'd34;
   localparam logic [5:0] ALU_MFLO    = 6'd35;

   localparam int TRAP_STALL           = 1;
   localparam int TRAP_BAD_INSTRUCTION = 2;
   localparam int TRAP_SYSCALL         = 3;
   localparam int TRAP_OVERFLOW        = 4;

   localparam logic [1:0] MW_NONE = 2'b00;
   localparam logic [1:0] MW_BYTE = 2'b01;
   localparam logic [1:0] MW_WORD = 2'b11;

   typedef struct packed {
      logic        reg_write_en;
      logic        alu_const_as_rs;
      logic        alu_const_as_rt;
      logic        alu_check_overflow;
      logic        mem_write_en;
      logic        mem2reg_en;
      logic        mem2reg_zext;
      logic        hilo_write_en;
      logic [1:0]  maccess_width;
      logic [31:0] alu_const;
      logic [5:0]  alu_op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } bundle_t;

   function automatic bundle_t idle_bundle();
      bundle_t b;
      b = '0;
      b.alu_op = ALU_STALL;
      return b;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch -> decode -> execute handshake plus the decoded control bundle.
// The stage uses the slave view; the surrounding pipeline uses master.
interface decode_stage_if #(
   parameter int EXC_W = 8
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      ir;
   logic [EXC_W-1:0] exception_in;
   logic             out_valid;
   logic             out_ready;
   logic             reg_write_en;
   logic             alu_const_as_rs;
   logic             alu_const_as_rt;
   logic             alu_check_overflow;
   logic             mem_write_en;
   logic             mem2reg_en;
   logic             mem2reg_zext;
   logic             hilo_write_en;
   logic [1:0]       maccess_width;
   logic [31:0]      alu_const;
   logic [5:0]       alu_op;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic [EXC_W-1:0] exception;

   modport slave (
      input  flush, in_valid, ir, exception_in, out_ready,
      output in_ready, out_valid, reg_write_en, alu_const_as_rs, alu_const_as_rt,
             alu_check_overflow, mem_write_en, mem2reg_en, mem2reg_zext,
             hilo_write_en, maccess_width, alu_const, alu_op, rs, rt, rd, exception
   );

   modport master (
      output flush, in_valid, ir, exception_in, out_ready,
      input  in_ready, out_valid, reg_write_en, alu_const_as_rs, alu_const_as_rt,
             alu_check_overflow, mem_write_en, mem2reg_en, mem2reg_zext,
             hilo_write_en, maccess_width, alu_const, alu_op, rs, rt, rd, exception
   );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: ir -> control bundle, trap code
// and which source registers the encoding actually reads.
module decode_comb
   import cpu_pkg::*;
#(
   parameter bit ENABLE_MULDIV = 1'b0,
   parameter int EXC_W         = 8
) (
   input  logic [31:0]      ir,
   output bundle_t          bundle,
   output logic [EXC_W-1:0] exception,
   output logic             uses_rs,
   output logic             uses_rt
);
   logic [5:0]  op;
   logic [5:0]  fn;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic        valid;

   assign op       = ir[31:26];
   assign fn       = ir[5:0];
   assign imm_sext = {{16{ir[15]}}, ir[15:0]};
   assign imm_zext = {16'h0000, ir[15:0]};

   always_comb begin
      bundle    = idle_bundle();
      bundle.rs = ir[25:21];
      bundle.rt = ir[20:16];
      exception = '0;
      valid     = 1'b1;
      uses_rs   = 1'b0;
      uses_rt   = 1'b0;
      case (op)
         OP_SPECIAL: begin
            bundle.rd           = ir[15:11];
            bundle.reg_write_en = 1'b1;
            uses_rs             = 1'b1;
            uses_rt             = 1'b1;
            case (fn)
               FN_SLL, FN_SRL, FN_SRA: begin
                  bundle.alu_op = (fn == FN_SLL) ? ALU_SLL : (fn == FN_SRL) ? ALU_SRL : ALU_SRA;
                  bundle.alu_const       = {27'd0, ir[10:6]};
                  bundle.alu_const_as_rs = 1'b1;
                  uses_rs                = 1'b0;
               end
               FN_SLLV: bundle.alu_op = ALU_SLLV;
               FN_SRLV: bundle.alu_op = ALU_SRLV;
               FN_SRAV: bundle.alu_op = ALU_SRAV;
               FN_JR: begin
                  bundle.alu_op       = ALU_JR;
                  bundle.reg_write_en = 1'b0;
                  bundle.rd           = 5'd0;
                  uses_rt             = 1'b0;
               end
               FN_JALR: begin
                  bundle.alu_op = ALU_JALR;
                  uses_rt       = 1'b0;
               end
               FN_SYSCALL: begin
                  bundle.alu_op       = ALU_SYSCALL;
                  bundle.reg_write_en = 1'b0;
                  bundle.rd           = 5'd0;
                  exception           = EXC_W'(TRAP_SYSCALL);
                  uses_rs             = 1'b0;
                  uses_rt             = 1'b0;
               end
               FN_ADD:  begin bundle.alu_op = ALU_ADD; bundle.alu_check_overflow = 1'b1; end
               FN_ADDU: bundle.alu_op = ALU_ADDU;
               FN_SUB:  begin bundle.alu_op = ALU_SUB; bundle.alu_check_overflow = 1'b1; end
               FN_SUBU: bundle.alu_op = ALU_SUBU;
               FN_AND:  bundle.alu_op = ALU_AND;
               FN_OR:   bundle.alu_op = ALU_OR;
               FN_XOR:  bundle.alu_op = ALU_XOR;
               FN_NOR:  bundle.alu_op = ALU_NOR;
               FN_SLT:  bundle.alu_op = ALU_SLT;
               FN_SLTU: bundle.alu_op = ALU_SLTU;
               FN_MFHI, FN_MFLO: begin
                  valid         = ENABLE_MULDIV;
                  bundle.alu_op = (fn == FN_MFHI) ? ALU_MFHI : ALU_MFLO;
                  uses_rs       = 1'b0;
                  uses_rt       = 1'b0;
               end
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  valid                = ENABLE_MULDIV;
                  bundle.alu_op        = (fn == FN_MULT)  ? ALU_MULT  :
                                         (fn == FN_MULTU) ? ALU_MULTU :
                                         (fn == FN_DIV)   ? ALU_DIV   : ALU_DIVU;
                  bundle.reg_write_en  = 1'b0;
                  bundle.hilo_write_en = 1'b1;
                  bundle.rd            = 5'd0;
               end
               default: valid = 1'b0;
            endcase
         end
         OP_REGIMM: begin
            bundle.alu_const = imm_sext;
            uses_rs          = 1'b1;
            case (ir[20:16])
               RI_BLTZ: bundle.alu_op = ALU_BLTZ;
               RI_BGEZ: bundle.alu_op = ALU_BGEZ;
               RI_BAL: begin
                  bundle.alu_op       = ALU_BAL;
                  bundle.rd           = 5'd31;
                  bundle.reg_write_en = 1'b1;
               end
               default: valid = 1'b0;
            endcase
         end
         OP_J, OP_JAL: begin
            bundle.alu_const = {4'd0, ir[25:0], 2'b00};
            bundle.alu_op    = (op == OP_J) ? ALU_J : ALU_JAL;
            if (op == OP_JAL) begin
               bundle.rd           = 5'd31;
               bundle.reg_write_en = 1'b1;
            end
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
            bundle.alu_const = imm_sext;
            bundle.alu_op    = (op == OP_BEQ) ? ALU_BEQ : (op == OP_BNE) ? ALU_BNE :
                               (op == OP_BLEZ) ? ALU_BLEZ : ALU_BGTZ;
            uses_rs          = 1'b1;
            uses_rt          = (op == OP_BEQ) || (op == OP_BNE);
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            bundle.rd              = ir[20:16];
            bundle.reg_write_en    = 1'b1;
            bundle.alu_const_as_rt = 1'b1;
            bundle.alu_const       = imm_sext;
            uses_rs                = 1'b1;
            case (op)
               OP_ADDI:  begin bundle.alu_op = ALU_ADD; bundle.alu_check_overflow = 1'b1; end
               OP_ADDIU: bundle.alu_op = ALU_ADDU;
               OP_SLTI:  bundle.alu_op = ALU_SLT;
               OP_SLTIU: bundle.alu_op = ALU_SLTU;
               OP_ANDI:  begin bundle.alu_op = ALU_AND; bundle.alu_const = imm_zext; end
               OP_ORI:   begin bundle.alu_op = ALU_OR;  bundle.alu_const = imm_zext; end
               OP_XORI:  begin bundle.alu_op = ALU_XOR; bundle.alu_const = imm_zext; end
               default: begin
                  bundle.alu_op    = ALU_LUI;
                  bundle.alu_const = {ir[15:0], 16'h0000};
                  uses_rs          = 1'b0;
               end
            endcase
         end
         OP_LB, OP_LW, OP_LBU: begin
            bundle.rd              = ir[20:16];
            bundle.reg_write_en    = 1'b1;
            bundle.alu_op          = ALU_ADDU;
            bundle.alu_const       = imm_sext;
            bundle.alu_const_as_rt = 1'b1;
            bundle.mem2reg_en      = 1'b1;
            bundle.mem2reg_zext    = (op == OP_LBU);
            bundle.maccess_width   = (op == OP_LW) ? MW_WORD : MW_BYTE;
            uses_rs                = 1'b1;
         end
         OP_SB, OP_SW: begin
            bundle.alu_op          = ALU_ADDU;
            bundle.alu_const       = imm_sext;
            bundle.alu_const_as_rt = 1'b1;
            bundle.mem_write_en    = 1'b1;
            bundle.maccess_width   = (op == OP_SW) ? MW_WORD : MW_BYTE;
            uses_rs                = 1'b1;
            uses_rt                = 1'b1;
         end
         default: valid = 1'b0;
      endcase
      // Anything unrecognised collapses to an inert bundle carrying the trap.
      if (!valid) begin
         bundle    = idle_bundle();
         exception = EXC_W'(TRAP_BAD_INSTRUCTION);
         uses_rs   = 1'b0;
         uses_rt   = 1'b0;
      end
   end
endmodule

// File: rtl/decode_stage.sv
// Handshaked decode stage: registers one decoded bundle per transfer and
// stalls dependants of a load until the load result can be forwarded.
module decode_stage
   import cpu_pkg::*;
#(
   parameter bit ENABLE_MULDIV    = 1'b0,
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int EXC_W            = 8
) (
   input  logic clk,
   input  logic rst,
   decode_stage_if.slave bus
);
   // The held load already costs one dead cycle, so the counter covers the rest.
   localparam logic [1:0] BUB_LOAD = (LOAD_USE_BUBBLES > 0) ? 2'(LOAD_USE_BUBBLES - 1) : 2'd0;
   localparam bit HELD_LOAD_STALLS = (LOAD_USE_BUBBLES != 0);

   bundle_t          bundle_q, bundle_d;
   logic [EXC_W-1:0] exception_q, exception_d;
   logic             out_valid_q, out_valid_d;
   logic [4:0]       pend_rd_q, pend_rd_d;
   logic [1:0]       bub_cnt_q, bub_cnt_d;

   bundle_t          dec_bundle;
   logic [EXC_W-1:0] dec_exception;
   logic             uses_rs, uses_rt;
   bundle_t          in_bundle;
   logic [EXC_W-1:0] in_exception;
   logic             hit_pend, hit_held, hazard;
   logic             in_ready, xfer_in, xfer_out;

   decode_comb #(
      .ENABLE_MULDIV(ENABLE_MULDIV),
      .EXC_W        (EXC_W)
   ) u_decode_comb (
      .ir       (bus.ir),
      .bundle   (dec_bundle),
      .exception(dec_exception),
      .uses_rs  (uses_rs),
      .uses_rt  (uses_rt)
   );

   assign in_bundle    = (bus.exception_in != '0) ? idle_bundle() : dec_bundle;
   assign in_exception = (bus.exception_in != '0) ? bus.exception_in : dec_exception;

   assign hit_pend = (pend_rd_q != 5'd0) &&
                     ((uses_rs && bus.ir[25:21] == pend_rd_q) || (uses_rt && bus.ir[20:16] == pend_rd_q));
   assign hit_held = (bundle_q.rd != 5'd0) &&
                     ((uses_rs && bus.ir[25:21] == bundle_q.rd) || (uses_rt && bus.ir[20:16] == bundle_q.rd));
   assign hazard   = ((bub_cnt_q != 2'd0) && hit_pend) ||
                     (out_valid_q && bundle_q.mem2reg_en && hit_held && (HELD_LOAD_STALLS || !bus.out_ready));

   assign in_ready = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
   assign xfer_in  = bus.in_valid && in_ready;
   assign xfer_out = out_valid_q && bus.out_ready;

   always_comb begin
      bundle_d    = bundle_q;
      exception_d = exception_q;
      out_valid_d = out_valid_q;
      pend_rd_d   = pend_rd_q;
      bub_cnt_d   = (bub_cnt_q != 2'd0) ? bub_cnt_q - 2'd1 : 2'd0;
      if (xfer_out && bundle_q.mem2reg_en && bundle_q.rd != 5'd0) begin
         pend_rd_d = bundle_q.rd;
         bub_cnt_d = BUB_LOAD;
      end
      if (xfer_in) begin
         bundle_d    = in_bundle;
         exception_d = in_exception;
         out_valid_d = 1'b1;
      end else if (xfer_out) begin
         out_valid_d = 1'b0;
      end
      if (bus.flush) begin
         bundle_d    = idle_bundle();
         exception_d = '0;
         out_valid_d = 1'b0;
         pend_rd_d   = 5'd0;
         bub_cnt_d   = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bundle_q    <= idle_bundle();
         exception_q <= EXC_W'(TRAP_STALL);
         out_valid_q <= 1'b0;
         pend_rd_q   <= 5'd0;
         bub_cnt_q   <= 2'd0;
      end else begin
         bundle_q    <= bundle_d;
         exception_q <= exception_d;
         out_valid_q <= out_valid_d;
         pend_rd_q   <= pend_rd_d;
         bub_cnt_q   <= bub_cnt_d;
      end
   end

   assign bus.in_ready           = in_ready;
   assign bus.out_valid          = out_valid_q;
   assign bus.reg_write_en       = bundle_q.reg_write_en;
   assign bus.alu_const_as_rs    = bundle_q.alu_const_as_rs;
   assign bus.alu_const_as_rt    = bundle_q.alu_const_as_rt;
   assign bus.alu_check_overflow = bundle_q.alu_check_overflow;
   assign bus.mem_write_en       = bundle_q.mem_write_en;
   assign bus.mem2reg_en         = bundle_q.mem2reg_en;
   assign bus.mem2reg_zext       = bundle_q.mem2reg_zext;
   assign bus.hilo_write_en      = bundle_q.hilo_write_en;
   assign bus.maccess_width      = bundle_q.maccess_width;
   assign bus.alu_const          = bundle_q.alu_const;
   assign bus.alu_op             = bundle_q.alu_op;
   assign bus.rs                 = bundle_q.rs;
   assign bus.rt                 = bundle_q.rt;
   assign bus.rd                 = bundle_q.rd;
   assign bus.exception          = exception_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances (muldiv off / on) share the
// same input stimulus; inputs change and outputs are sampled on the falling edge.
module tb_decode_stage;
   import cpu_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   decode_stage_if #(.EXC_W(8)) bus0 ();
   decode_stage_if #(.EXC_W(8)) bus1 ();

   decode_stage #(.ENABLE_MULDIV(1'b0), .LOAD_USE_BUBBLES(1), .EXC_W(8))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   decode_stage #(.ENABLE_MULDIV(1'b1), .LOAD_USE_BUBBLES(1), .EXC_W(8))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   assign bus1.flush        = bus0.flush;
   assign bus1.in_valid     = bus0.in_valid;
   assign bus1.ir           = bus0.ir;
   assign bus1.exception_in = bus0.exception_in;
   assign bus1.out_ready    = bus0.out_ready;

   localparam logic [31:0] I_ADDU_3_1_2 = 32'h0022_1821;
   localparam logic [31:0] I_ORI_4_3_FF = 32'h3464_00FF;
   localparam logic [31:0] I_LW_5_0_1   = 32'h8C25_0000;
   localparam logic [31:0] I_ADDU_6_5_2 = 32'h00A2_3021;
   localparam logic [31:0] I_ADDU_6_7_2 = 32'h00E2_3021;
   localparam logic [31:0] I_JAL        = 32'h0C10_0000;
   localparam logic [31:0] I_SW_2_4_1   = 32'hAC22_0004;
   localparam logic [31:0] I_BEQ_1_2    = 32'h1022_0010;
   localparam logic [31:0] I_MULT_1_2   = 32'h0022_0018;
   localparam logic [31:0] I_BAL        = 32'h0411_0010;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic idle_inputs();
      bus0.flush        = 1'b0;
      bus0.in_valid     = 1'b0;
      bus0.ir           = 32'h0;
      bus0.exception_in = 8'h00;
      bus0.out_ready    = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus0.out_valid); end
      checks++; if (bus0.exception !== 8'd1) begin errors++; $display("FAIL reset_exception got %0d want 1", bus0.exception); end
      checks++; if (bus0.alu_op !== ALU_STALL || bus0.alu_const !== 32'h0 || bus0.rd !== 5'd0 || bus0.reg_write_en !== 1'b0) begin
         errors++; $display("FAIL reset_bundle got op=%0d const=%h rd=%0d rwe=%0b want op=0 const=0 rd=0 rwe=0", bus0.alu_op, bus0.alu_const, bus0.rd, bus0.reg_write_en);
      end
      #1;
      checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus0.in_ready); end
      $display("test_reset done");
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus0.in_valid = 1'b1; bus0.ir = I_ADDU_3_1_2;
      #1;
      checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %0b want 1", bus0.in_ready); end
      @(negedge clk);
      checks++; if (bus0.out_valid !== 1'b1 || bus0.rd !== 5'd3 || bus0.alu_op !== ALU_ADDU || bus0.reg_write_en !== 1'b1) begin
         errors++; $display("FAIL b2b_first got v=%0b rd=%0d op=%0d rwe=%0b want v=1 rd=3 op=%0d rwe=1", bus0.out_valid, bus0.rd, bus0.alu_op, bus0.reg_write_en, ALU_ADDU);
      end
      bus0.ir = I_ORI_4_3_FF;
      #1;
      checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %0b want 1", bus0.in_ready); end
      @(negedge clk);
      bus0.in_valid = 1'b0;
      checks++; if (bus0.out_valid !== 1'b1 || bus0.rd !== 5'd4 || bus0.alu_const !== 32'h0000_00FF || bus0.alu_const_as_rt !== 1'b1) begin
         errors++; $display("FAIL b2b_second got v=%0b rd=%0d const=%h as_rt=%0b want v=1 rd=4 const=000000ff as_rt=1", bus0.out_valid, bus0.rd, bus0.alu_const, bus0.alu_const_as_rt);
      end
      @(negedge clk);
      checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", bus0.out_valid); end
      $display("test_back_to_back done");
   endtask

   task automatic test_load_use();
      int  bubbles;
      bit  got;
      bit  acc;
      bubbles = 0; got = 1'b0;
      @(negedge clk);
      bus0.in_valid = 1'b1; bus0.ir = I_LW_5_0_1;
      @(negedge clk);
      checks++; if (bus0.out_valid !== 1'b1 || bus0.mem2reg_en !== 1'b1 || bus0.rd !== 5'd5 || bus0.maccess_width !== 2'b11) begin
         errors++; $display("FAIL lu_load got v=%0b m2r=%0b rd=%0d w=%b want v=1 m2r=1 rd=5 w=11", bus0.out_valid, bus0.mem2reg_en, bus0.rd, bus0.maccess_width);
      end
      bus0.ir = I_ADDU_6_5_2;
      #1;
      acc = bus0.in_ready;
      checks++; if (acc !== 1'b0) begin errors++; $display("FAIL lu_hazard_ready got %0b want 0", acc); end
      for (int c = 0; c < 8 && !got; c++) begin
         @(negedge clk);
         if (acc) bus0.in_valid = 1'b0;
         if (bus0.out_valid && bus0.rd == 5'd6) begin
            got = 1'b1;
            bus0.in_valid = 1'b0;
         end else if (!bus0.out_valid) begin
            bubbles++;
         end
         #1;
         if (bus0.in_valid && bus0.in_ready) acc = 1'b1;
      end
      checks++; if (!got || bubbles != 1) begin errors++; $display("FAIL lu_bubbles got arrived=%0b bubbles=%0d want arrived=1 bubbles=1", got, bubbles); end
      @(negedge clk);
      bus0.in_valid = 1'b1; bus0.ir = I_LW_5_0_1;
      @(negedge clk);
      bus0.ir = I_ADDU_6_7_2;
      #1;
      checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL lu_indep_ready got %0b want 1", bus0.in_ready); end
      @(negedge clk);
      bus0.in_valid = 1'b0;
      checks++; if (bus0.out_valid !== 1'b1 || bus0.rd !== 5'd6 || bus0.rs !== 5'd7) begin
         errors++; $display("FAIL lu_indep got v=%0b rd=%0d rs=%0d want v=1 rd=6 rs=7", bus0.out_valid, bus0.rd, bus0.rs);
      end
      @(negedge clk);
      $display("test_load_use done bubbles=%0d", bubbles);
   endtask

   task automatic test_hold();
      @(negedge clk);
      bus0.in_valid = 1'b1; bus0.ir = I_JAL; bus0.out_ready = 1'b0;
      @(negedge clk);
      bus0.ir = I_ORI_4_3_FF;
      for (int c = 0; c < 3; c++) begin
         checks++; if (bus0.out_valid !== 1'b1 || bus0.alu_const !== 32'h0040_0000 || bus0.rd !== 5'd31 || bus0.alu_op !== ALU_JAL || bus0.reg_write_en !== 1'b1) begin
            errors++; $display("FAIL hold_cycle%0d got v=%0b const=%h rd=%0d op=%0d want v=1 const=00400000 rd=31 op=%0d", c, bus0.out_valid, bus0.alu_const, bus0.rd, bus0.alu_op, ALU_JAL);
         end
         #1;
         checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready%0d got %0b want 0", c, bus0.in_ready); end
         @(negedge clk);
      end
      bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %0b want 0", bus0.out_valid); end
      $display("test_hold done");
   endtask

   task automatic test_flush();
      @(negedge clk);
      bus0.in_valid = 1'b1; bus0.ir = I_SW_2_4_1; bus0.out_ready = 1'b0;
      @(negedge clk);
      checks++; if (bus0.out_valid !== 1'b1 || bus0.mem_write_en !== 1'b1 || bus0.rd !== 5'd0 || bus0.alu_const !== 32'h4) begin
         errors++; $display("FAIL flush_sw got v=%0b mw=%0b rd=%0d const=%h want v=1 mw=1 rd=0 const=4", bus0.out_valid, bus0.mem_write_en, bus0.rd, bus0.alu_const);
      end
      bus0.ir = I_BEQ_1_2; bus0.flush = 1'b1;
      #1;
      checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b want 0", bus0.in_ready); end
      @(negedge clk);
      bus0.flush = 1'b0; bus0.out_ready = 1'b1;
      checks++; if (bus0.out_valid !== 1'b0 || bus0.exception !== 8'd0 || bus0.mem_write_en !== 1'b0 || bus0.alu_op !== ALU_STALL) begin
         errors++; $display("FAIL flush_clear got v=%0b exc=%0d mw=%0b op=%0d want v=0 exc=0 mw=0 op=0", bus0.out_valid, bus0.exception, bus0.mem_write_en, bus0.alu_op);
      end
      #1;
      checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL flush_reready got %0b want 1", bus0.in_ready); end
      @(negedge clk);
      bus0.in_valid = 1'b0;
      checks++; if (bus0.out_valid !== 1'b1 || bus0.alu_op !== ALU_BEQ || bus0.alu_const !== 32'h10 || bus0.rs !== 5'd1 || bus0.rt !== 5'd2 || bus0.reg_write_en !== 1'b0) begin
         errors++; $display("FAIL flush_beq got v=%0b op=%0d const=%h rs=%0d rt=%0d rwe=%0b want v=1 op=%0d const=10 rs=1 rt=2 rwe=0", bus0.out_valid, bus0.alu_op, bus0.alu_const, bus0.rs, bus0.rt, bus0.reg_write_en, ALU_BEQ);
      end
      @(negedge clk);
      $display("test_flush done");
   endtask

   task automatic test_muldiv();
      @(negedge clk);
      bus0.in_valid = 1'b1; bus0.ir = I_MULT_1_2;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      checks++; if (bus0.out_valid !== 1'b1 || bus0.exception !== 8'd2 || bus0.reg_write_en !== 1'b0 || bus0.hilo_write_en !== 1'b0) begin
         errors++; $display("FAIL muldiv_off got v=%0b exc=%0d rwe=%0b hilo=%0b want v=1 exc=2 rwe=0 hilo=0", bus0.out_valid, bus0.exception, bus0.reg_write_en, bus0.hilo_write_en);
      end
      checks++; if (bus1.out_valid !== 1'b1 || bus1.exception !== 8'd0 || bus1.hilo_write_en !== 1'b1 || bus1.alu_op !== ALU_MULT || bus1.reg_write_en !== 1'b0) begin
         errors++; $display("FAIL muldiv_on got v=%0b exc=%0d hilo=%0b op=%0d rwe=%0b want v=1 exc=0 hilo=1 op=%0d rwe=0", bus1.out_valid, bus1.exception, bus1.hilo_write_en, bus1.alu_op, bus1.reg_write_en, ALU_MULT);
      end
      @(negedge clk);
      $display("test_muldiv done");
   endtask

   task automatic test_bal();
      @(negedge clk);
      bus0.in_valid = 1'b1; bus0.ir = I_BAL;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      checks++; if (bus0.out_valid !== 1'b1 || bus0.alu_op !== ALU_BAL || bus0.rd !== 5'd31 || bus0.reg_write_en !== 1'b1 || bus0.alu_const !== 32'h10) begin
         errors++; $display("FAIL bal got v=%0b op=%0d rd=%0d rwe=%0b const=%h want v=1 op=%0d rd=31 rwe=1 const=10", bus0.out_valid, bus0.alu_op, bus0.rd, bus0.reg_write_en, bus0.alu_const, ALU_BAL);
      end
      @(negedge clk);
      $display("test_bal done");
   endtask

   task automatic test_exception_in();
      @(negedge clk);
      bus0.in_valid = 1'b1; bus0.ir = I_ADDU_3_1_2; bus0.exception_in = 8'd3;
      @(negedge clk);
      bus0.in_valid = 1'b0; bus0.exception_in = 8'd0;
      checks++; if (bus0.out_valid !== 1'b1 || bus0.exception !== 8'd3 || bus0.alu_op !== ALU_STALL) begin
         errors++; $display("FAIL excin_code got v=%0b exc=%0d op=%0d want v=1 exc=3 op=0", bus0.out_valid, bus0.exception, bus0.alu_op);
      end
      checks++; if (bus0.reg_write_en !== 1'b0 || bus0.mem_write_en !== 1'b0 || bus0.hilo_write_en !== 1'b0 || bus0.mem2reg_en !== 1'b0) begin
         errors++; $display("FAIL excin_enables got rwe=%0b mw=%0b hilo=%0b m2r=%0b want all 0", bus0.reg_write_en, bus0.mem_write_en, bus0.hilo_write_en, bus0.mem2reg_en);
      end
      @(negedge clk);
      $display("test_exception_in done");
   endtask

   task automatic test_reset_stall();
      @(negedge clk);
      bus0.in_valid = 1'b1; bus0.ir = I_LW_5_0_1; bus0.out_ready = 1'b0;
      @(negedge clk);
      bus0.ir = I_ADDU_6_5_2; bus0.out_ready = 1'b1;
      #1;
      checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL rststall_ready got %0b want 0", bus0.in_ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
         errors++; $display("FAIL rststall_after got ready=%0b v=%0b want ready=1 v=0", bus0.in_ready, bus0.out_valid);
      end
      @(negedge clk);
      bus0.in_valid = 1'b0;
      @(negedge clk);
      $display("test_reset_stall done");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_back_to_back();
      test_load_use();
      test_hold();
      test_flush();
      test_muldiv();
      test_bal();
      test_exception_in();
      test_reset_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
